// File: rtl/sram_1p_req_ctrl.sv
// ---------------------------------------------------------------------------
// sram_1p_req_ctrl
//
// Requester-side controller for a single-port SRAM macro (2**ADDR_BITS words
// of DATA_WIDTH bits). After reset, or when CLR is pulsed while running, the
// controller zero-fills the whole array. Then it forwards client read and
// write requests to the macro pins. Read data arriving on Q is captured into
// a small response FIFO that the client drains over a valid/ready channel.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   CLR               request a zero-fill of the array (ignored while clearing)
//   INIT_DONE         high while in the RUN state
//   REQ_VALID/READY   request handshake; REQ_WE selects write (1) or read (0)
//   REQ_ADR, REQ_D    request address and write data
//   RSP_VALID/READY   response handshake; RSP_Q is the registered FIFO head
//   ME, WE, ADR, D    macro enable, write enable, address and write data
//   Q                 macro read data, valid the cycle after a read is issued
// ---------------------------------------------------------------------------
module sram_1p_req_ctrl #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 64,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  output logic                  INIT_DONE,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_BITS-1:0]  REQ_ADR,
  input  logic [DATA_WIDTH-1:0] REQ_D,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_Q,
  output logic                  ME,
  output logic                  WE,
  output logic [ADDR_BITS-1:0]  ADR,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  clrCnt_q, clrCnt_d;
  logic                  rdPend_q, rdPend_d;
  logic [DATA_WIDTH-1:0] fifoMem_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      fifoCount_q;
  logic [OCC_W-1:0]      occ;
  logic                  reqReady;
  logic                  accept;
  logic                  meRaw;
  logic                  weRaw;
  logic                  push;
  logic                  pop;

  // Credits are counted from registered state only: entries already in the
  // FIFO plus a read whose data is still on its way from the macro. This keeps
  // REQ_READY free of any path from REQ_VALID, REQ_WE or RSP_READY.
  assign occ = OCC_W'(fifoCount_q) + OCC_W'(rdPend_q);

  // Next-state and macro-pin logic. While clearing, the counter walks every
  // address writing zeros; in RUN an accepted request drives the macro in the
  // same cycle. ADR/D follow the request inputs when idle so the pins do not
  // need their own registers.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    rdPend_d = 1'b0;
    reqReady = 1'b0;
    accept   = 1'b0;
    meRaw    = 1'b0;
    weRaw    = 1'b0;
    ADR      = REQ_ADR;
    D        = REQ_D;
    case (state_q)
      ST_CLEAR: begin
        meRaw    = 1'b1;
        weRaw    = 1'b1;
        ADR      = clrCnt_q;
        D        = '0;
        clrCnt_d = clrCnt_q + ADDR_BITS'(1);
        if (clrCnt_q == {ADDR_BITS{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        reqReady = !CLR && (occ < OCC_W'(RSP_DEPTH));
        accept   = REQ_VALID && reqReady;
        meRaw    = accept;
        weRaw    = accept && REQ_WE;
        rdPend_d = accept && !REQ_WE;
        if (CLR) begin
          state_d  = ST_CLEAR;
          clrCnt_d = '0;
        end
      end
      default: begin
        state_d  = ST_CLEAR;
        clrCnt_d = '0;
      end
    endcase
  end

  // The state register resets straight into CLEAR, so the reset value of the
  // enables would be 1; gating with RST_N keeps the macro idle during reset.
  assign ME        = meRaw && RST_N;
  assign WE        = weRaw && RST_N;
  assign REQ_READY = reqReady;
  assign INIT_DONE = (state_q == ST_RUN);

  // Control state registers: FSM state, clear counter and the one-cycle flag
  // marking that the macro's Q carries read data this cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_CLEAR;
      clrCnt_q <= '0;
      rdPend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
      rdPend_q <= rdPend_d;
    end
  end

  // Response FIFO. Q is pushed unconditionally in the cycle after a read
  // accept (the credit check guarantees room), independent of the FSM state,
  // so a read issued just before CLR still gets its data captured.
  assign push      = rdPend_q;
  assign RSP_VALID = (fifoCount_q != '0);
  assign pop       = RSP_VALID && RSP_READY;
  assign RSP_Q     = fifoMem_q[rdPtr_q];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= Q;
        wrPtr_q <= (wrPtr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + CNT_W'(1);
        2'b01:   fifoCount_q <= fifoCount_q - CNT_W'(1);
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_1p_req_ctrl
//
// Self-checking bench for sram_1p_req_ctrl with a behavioural model of the
// single-port macro (registered Q). Table-driven vectors cover post-init reads
// and back-to-back traffic; hand-written sequences cover backpressure, CLR with
// a read in flight and asynchronous reset in the middle of a clear.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge (or shortly after a rising edge for registered outputs).
// ---------------------------------------------------------------------------
module tb_sram_1p_req_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          CLR;
  logic          INIT_DONE;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WE;
  logic [AW-1:0] REQ_ADR;
  logic [DW-1:0] REQ_D;
  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_Q;
  logic          ME;
  logic          WE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;

  int nCompared   = 0;
  int nMismatched = 0;

  sram_1p_req_ctrl #(
    .ADDR_BITS (AW),
    .DATA_WIDTH(DW),
    .RSP_DEPTH (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLR      (CLR),
    .INIT_DONE(INIT_DONE),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WE   (REQ_WE),
    .REQ_ADR  (REQ_ADR),
    .REQ_D    (REQ_D),
    .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY),
    .RSP_Q    (RSP_Q),
    .ME       (ME),
    .WE       (WE),
    .ADR      (ADR),
    .D        (D),
    .Q        (Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural macro: writes land at the edge, reads register Q at the edge.
  // The array starts with non-zero garbage so the zero-fill is observable.
  logic [DW-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
  end

  always @(posedge CLK) begin
    if (ME) begin
      if (WE) mem[ADR] = D;
      else    Q <= mem[ADR];
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          valid;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] d;
    logic          rspRdy;
    logic          clr;
    logic          expReady;
    logic          expMe;
    logic          expWe;
    logic          expRv;
    logic          chkQ;
    logic [DW-1:0] expQ;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  localparam logic [DW-1:0] DATA_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] DATA_B = 64'hFFFF_0000_FFFF_0000;
  localparam logic [DW-1:0] DATA_C = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] DATA_E = 64'h5A5A_A5A5_0F0F_F0F0;
  localparam logic [DW-1:0] DATA_F = 64'h5555_5555_5555_5555;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK);
    #1;
    REQ_VALID = v.valid;
    REQ_WE    = v.we;
    REQ_ADR   = v.adr;
    REQ_D     = v.d;
    RSP_READY = v.rspRdy;
    CLR       = v.clr;
  endtask

  // Walks a full clear starting in its cycle 0: every cycle must be a zero
  // write to the next address with the request side closed.
  task automatic checkClear(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      if (ME !== 1'b1 || WE !== 1'b1 || ADR !== AW'(i) || D !== '0 ||
          REQ_READY !== 1'b0 || INIT_DONE !== 1'b0) begin
        bad++;
      end
    end
    checkOutput({tag, "_clearCyclesBad"}, DW'(bad), '0);
    @(negedge CLK);
    checkOutput({tag, "_initDoneAfterClear"}, DW'(INIT_DONE), 64'd1);
  endtask

  task automatic doWrite(input logic [AW-1:0] adr, input logic [DW-1:0] data);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADR   = adr;
    REQ_D     = data;
    @(negedge CLK);
    checkOutput("writeReady", DW'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
  endtask

  // Single read with RSP_READY held high; the response must appear within a
  // bounded number of cycles.
  task automatic doRead(input string name, input logic [AW-1:0] adr,
                        input logic [DW-1:0] exp);
    bit found = 0;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_ADR   = adr;
    @(negedge CLK);
    checkOutput({name, "_ready"}, DW'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      @(negedge CLK);
      if (RSP_VALID) found = 1;
    end
    checkOutput({name, "_rspSeen"}, DW'(found), 64'd1);
    if (found) checkOutput({name, "_data"}, RSP_Q, exp);
  endtask

  logic [AW-1:0] rdAdr  [6];
  logic [DW-1:0] rdData [6];

  initial begin
    int accepted;
    int nRsp;
    int fifthAcceptCycle;

    // Post-init reads (rows 0-4) then back-to-back writes/reads (rows 5-11).
    //            valid we  adr      d       rr   clr  rdy  me   we   rv   chkQ expQ
    vecs[0]  = '{1'b1, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[1]  = '{1'b1, 1'b0, 11'h005, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[2]  = '{1'b1, 1'b0, 11'h7FF, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, '0};
    vecs[3]  = '{1'b0, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0};
    vecs[4]  = '{1'b0, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0};
    vecs[5]  = '{1'b1, 1'b1, 11'h010, DATA_A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[6]  = '{1'b1, 1'b1, 11'h7FF, DATA_B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[7]  = '{1'b1, 1'b0, 11'h010, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[8]  = '{1'b1, 1'b0, 11'h7FF, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[9]  = '{1'b0, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, DATA_A};
    vecs[10] = '{1'b0, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, DATA_B};
    vecs[11] = '{1'b0, 1'b0, 11'h000, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};

    rdAdr[0] = 11'h010; rdData[0] = DATA_A;
    rdAdr[1] = 11'h7FF; rdData[1] = DATA_B;
    rdAdr[2] = 11'h020; rdData[2] = DATA_C;
    rdAdr[3] = 11'h021; rdData[3] = DATA_E;
    rdAdr[4] = 11'h010; rdData[4] = DATA_A;
    rdAdr[5] = 11'h7FF; rdData[5] = DATA_B;

    RST_N     = 1'b0;
    CLR       = 1'b0;
    REQ_VALID = 1'b0;
    REQ_WE    = 1'b0;
    REQ_ADR   = '0;
    REQ_D     = '0;
    RSP_READY = 1'b0;

    // ---- reset state -------------------------------------------------------
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_reqReady", DW'(REQ_READY), '0);
    checkOutput("rst_rspValid", DW'(RSP_VALID), '0);
    checkOutput("rst_rspQ",     RSP_Q,          '0);
    checkOutput("rst_initDone", DW'(INIT_DONE), '0);
    checkOutput("rst_me",       DW'(ME),        '0);
    checkOutput("rst_we",       DW'(WE),        '0);
    checkOutput("rst_adr",      DW'(ADR),       '0);
    checkOutput("rst_d",        D,              '0);

    // ---- initial clear -----------------------------------------------------
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    checkClear("init");

    // ---- table-driven vectors ----------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput($sformatf("vec%0d_reqReady", i), DW'(REQ_READY), DW'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d_me", i),       DW'(ME),        DW'(vecs[i].expMe));
      checkOutput($sformatf("vec%0d_we", i),       DW'(WE),        DW'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d_adr", i),      DW'(ADR),       DW'(vecs[i].adr));
      checkOutput($sformatf("vec%0d_rspValid", i), DW'(RSP_VALID), DW'(vecs[i].expRv));
      if (vecs[i].chkQ) begin
        checkOutput($sformatf("vec%0d_rspQ", i), RSP_Q, vecs[i].expQ);
      end
    end

    // ---- backpressure: 6 reads with RSP_READY low ----------------------------
    doWrite(11'h020, DATA_C);
    doWrite(11'h021, DATA_E);
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK);
      #1;
      RSP_READY = 1'b0;
      REQ_VALID = 1'b1;
      REQ_WE    = 1'b0;
      REQ_ADR   = rdAdr[accepted];
      @(negedge CLK);
      if (REQ_READY) accepted++;
    end
    checkOutput("bp_acceptedWhileStalled", DW'(accepted), 64'd4);
    checkOutput("bp_readyLow", DW'(REQ_READY), '0);

    nRsp = 0;
    fifthAcceptCycle = -1;
    for (int c = 0; c < 30 && nRsp < 6; c++) begin
      @(posedge CLK);
      #1;
      RSP_READY = 1'b1;
      REQ_VALID = (accepted < 6);
      REQ_ADR   = rdAdr[(accepted < 6) ? accepted : 5];
      @(negedge CLK);
      if (c == 0) checkOutput("bp_creditLag", DW'(REQ_READY), '0);
      if (REQ_VALID && REQ_READY) begin
        if (accepted == 4) fifthAcceptCycle = c;
        accepted++;
      end
      if (RSP_VALID && RSP_READY) begin
        checkOutput($sformatf("bp_rsp%0d", nRsp), RSP_Q, rdData[nRsp]);
        nRsp++;
      end
    end
    checkOutput("bp_rspCount", DW'(nRsp), 64'd6);
    checkOutput("bp_acceptedTotal", DW'(accepted), 64'd6);
    checkOutput("bp_fifthAcceptCycle", DW'(fifthAcceptCycle), 64'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;

    // ---- CLR with a read in flight -------------------------------------------
    RSP_READY = 1'b0;
    doWrite(11'h003, 64'hAA);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_ADR   = 11'h003;
    @(negedge CLK);
    checkOutput("clr_readAccepted", DW'(REQ_READY), 64'd1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    CLR       = 1'b1;
    @(negedge CLK);
    checkOutput("clr_readyForcedLow", DW'(REQ_READY), '0);
    checkOutput("clr_stillRun", DW'(INIT_DONE), 64'd1);
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    checkOutput("clr_initDoneDrops", DW'(INIT_DONE), '0);
    checkOutput("clr_rspValid", DW'(RSP_VALID), 64'd1);
    checkOutput("clr_rspData", RSP_Q, 64'hAA);
    RSP_READY = 1'b1;
    checkClear("clr");
    checkOutput("clr_fifoDrained", DW'(RSP_VALID), '0);
    doRead("clr_readAfter", 11'h003, '0);

    // ---- async reset mid-clear with two FIFO entries -------------------------
    doWrite(11'h010, DATA_F);
    RSP_READY = 1'b0;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_ADR   = 11'h010;
    @(posedge CLK);
    #1;
    REQ_ADR   = 11'h7FF;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    CLR       = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    checkOutput("ar_midClearAdr", DW'(ADR), 64'd50);
    checkOutput("ar_midClearRspValid", DW'(RSP_VALID), 64'd1);
    checkOutput("ar_midClearHead", RSP_Q, DATA_F);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("ar_rspValidDrops", DW'(RSP_VALID), '0);
    checkOutput("ar_meLow", DW'(ME), '0);
    checkOutput("ar_weLow", DW'(WE), '0);
    checkOutput("ar_adrZero", DW'(ADR), '0);
    checkOutput("ar_rspQZero", RSP_Q, '0);
    checkOutput("ar_initDone", DW'(INIT_DONE), '0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    checkClear("ar");
    checkOutput("ar_fifoEmptyAfter", DW'(RSP_VALID), '0);
    RSP_READY = 1'b1;
    doRead("ar_readAfter", 11'h010, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
